aria_rk_gen: RTL and testbench

- Generates the ARIA round keys for one cipher operation and streams them, one 128-bit key per transfer, over a valid/ready handshake into the round-key storage.
- The stored keys are later read back by the round datapath.
- The block takes the four key-schedule words W0..W3 and the key size, and emits nk = 13, 15 or 17 round keys.
- Keys are emitted in encryption order. With the decryption feature compiled in, they are emitted in decryption order, diffusion-transformed.

---
 rtl/aria_rk_gen.sv | 193 +++++++++++++++++++
 tb/tb_aria_rk_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aria_rk_gen.sv
// ARIA round-key generator: streams ek_1..ek_nk (or the diffusion-transformed decryption
// order when ARIA_RKGEN_DEC_EN is defined) over a valid/ready handshake.
module aria_rk_gen (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         clr,
  input  logic [1:0]   st_ksize,
  input  logic         flg_dec,
  input  logic [127:0] w0,
  input  logic [127:0] w1,
  input  logic [127:0] w2,
  input  logic [127:0] w3,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [4:0]   rk_idx,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state_q;
  logic [3:0][127:0]  w_q;
  logic [4:0]         nk_q;
  logic               rk_valid_q;
  logic [127:0]       rk_data_q;
  logic [4:0]         rk_idx_q;
  logic               busy_q;
  logic               done_q;

  logic [3:0][127:0]  w_in;
  logic [4:0]         nk_d;
  logic [4:0]         idx_inc;
  logic               xfer;
  logic [127:0]       first_key;
  logic [127:0]       next_key;

  // ek_i for i = 1..17; the word pair and rotation come straight from the index
  function automatic logic [127:0] ek_fn(input logic [3:0][127:0] w, input logic [4:0] i);
    logic [4:0]   jm;
    logic [1:0]   g;
    logic [1:0]   k;
    logic [127:0] wa;
    logic [127:0] wb;
    logic [127:0] rot;
    jm  = i - 5'd1;
    g   = jm[3:2];
    k   = jm[1:0];
    wa  = w[k];
    wb  = w[k + 2'd1];
    case (g)
      2'd0:    rot = {wb[18:0], wb[127:19]};
      2'd1:    rot = {wb[30:0], wb[127:31]};
      2'd2:    rot = {wb[66:0], wb[127:67]};
      default: rot = {wb[96:0], wb[127:97]};
    endcase
    if (i == 5'd17) begin
      ek_fn = w[0] ^ {w[1][108:0], w[1][127:109]};
    end else begin
      ek_fn = wa ^ rot;
    end
  endfunction

`ifdef ARIA_RKGEN_DEC_EN
  logic        dec_q;
  logic [4:0]  sel_idx;
  logic [127:0] ek_sel;

  // ARIA diffusion layer A; b[0] is the most significant byte
  function automatic logic [127:0] a_layer(input logic [127:0] x);
    logic [0:15][7:0] b;
    b = x;
    a_layer = {
      b[3] ^ b[4] ^ b[6] ^ b[8]  ^ b[9]  ^ b[13] ^ b[14],
      b[2] ^ b[5] ^ b[7] ^ b[8]  ^ b[9]  ^ b[12] ^ b[15],
      b[1] ^ b[4] ^ b[6] ^ b[10] ^ b[11] ^ b[12] ^ b[15],
      b[0] ^ b[5] ^ b[7] ^ b[10] ^ b[11] ^ b[13] ^ b[14],
      b[0] ^ b[2] ^ b[5] ^ b[8]  ^ b[11] ^ b[14] ^ b[15],
      b[1] ^ b[3] ^ b[4] ^ b[9]  ^ b[10] ^ b[14] ^ b[15],
      b[0] ^ b[2] ^ b[7] ^ b[9]  ^ b[10] ^ b[12] ^ b[13],
      b[1] ^ b[3] ^ b[6] ^ b[8]  ^ b[11] ^ b[12] ^ b[13],
      b[0] ^ b[1] ^ b[4] ^ b[7]  ^ b[10] ^ b[13] ^ b[15],
      b[0] ^ b[1] ^ b[5] ^ b[6]  ^ b[11] ^ b[12] ^ b[14],
      b[2] ^ b[3] ^ b[5] ^ b[6]  ^ b[8]  ^ b[13] ^ b[15],
      b[2] ^ b[3] ^ b[4] ^ b[7]  ^ b[9]  ^ b[12] ^ b[14],
      b[1] ^ b[2] ^ b[6] ^ b[7]  ^ b[9]  ^ b[11] ^ b[12],
      b[0] ^ b[3] ^ b[6] ^ b[7]  ^ b[8]  ^ b[10] ^ b[13],
      b[0] ^ b[3] ^ b[4] ^ b[5]  ^ b[9]  ^ b[11] ^ b[14],
      b[1] ^ b[2] ^ b[4] ^ b[5]  ^ b[8]  ^ b[10] ^ b[15]
    };
  endfunction

  // Decryption: first key is ek_nk, last is ek_1, the middle ones go through A
  always_comb begin
    first_key = ek_fn(w_in, flg_dec ? nk_d : 5'd1);
    if (dec_q) begin
      sel_idx = (idx_inc == nk_q) ? 5'd1 : (nk_q - rk_idx_q);
    end else begin
      sel_idx = idx_inc;
    end
    ek_sel   = ek_fn(w_q, sel_idx);
    next_key = (dec_q && (idx_inc != nk_q)) ? a_layer(ek_sel) : ek_sel;
  end
`else
  logic unused_flg_dec;
  assign unused_flg_dec = flg_dec;

  always_comb begin
    first_key = ek_fn(w_in, 5'd1);
    next_key  = ek_fn(w_q, idx_inc);
  end
`endif

  assign w_in    = {w3, w2, w1, w0};
  assign idx_inc = rk_idx_q + 5'd1;
  assign xfer    = rk_valid_q & rk_ready;

  always_comb begin
    case (st_ksize)
      2'b10:   nk_d = 5'd15;
      2'b11:   nk_d = 5'd17;
      default: nk_d = 5'd13;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      w_q        <= '0;
      nk_q       <= 5'd13;
      rk_valid_q <= 1'b0;
      rk_data_q  <= '0;
      rk_idx_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef ARIA_RKGEN_DEC_EN
      dec_q      <= 1'b0;
`endif
    end else if (clr) begin
      state_q    <= S_IDLE;
      rk_valid_q <= 1'b0;
      rk_data_q  <= '0;
      rk_idx_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            w_q        <= w_in;
            nk_q       <= nk_d;
`ifdef ARIA_RKGEN_DEC_EN
            dec_q      <= flg_dec;
`endif
            rk_idx_q   <= 5'd1;
            rk_data_q  <= first_key;
            rk_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          if (xfer) begin
            if (rk_idx_q == nk_q) begin
              rk_valid_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= S_DONE;
            end else begin
              rk_idx_q  <= idx_inc;
              rk_data_q <= next_key;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rk_valid = rk_valid_q;
  assign rk_data  = rk_data_q;
  assign rk_idx   = rk_idx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_aria_rk_gen.sv
// Scoreboard bench for aria_rk_gen: expected keys are queued at start, popped on each transfer.
module tb_aria_rk_gen;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         clr = 1'b0;
  logic [1:0]   st_ksize = 2'b00;
  logic         flg_dec = 1'b0;
  logic [127:0] w0 = '0, w1 = '0, w2 = '0, w3 = '0;
  logic         rk_valid;
  logic         rk_ready = 1'b0;
  logic [127:0] rk_data;
  logic [4:0]   rk_idx;
  logic         busy;
  logic         done;

  aria_rk_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clr(clr), .st_ksize(st_ksize),
    .flg_dec(flg_dec), .w0(w0), .w1(w1), .w2(w2), .w3(w3),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data), .rk_idx(rk_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

`ifdef ARIA_RKGEN_DEC_EN
  localparam bit DEC_BUILD = 1'b1;
`else
  localparam bit DEC_BUILD = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_data_q[$];
  logic [4:0]   exp_idx_q[$];
  logic [127:0] cap [1:17];

  // Input byte indices feeding each output byte of the diffusion layer
  int atab [16][7] = '{
    '{3,4,6,8,9,13,14},  '{2,5,7,8,9,12,15},  '{1,4,6,10,11,12,15}, '{0,5,7,10,11,13,14},
    '{0,2,5,8,11,14,15}, '{1,3,4,9,10,14,15}, '{0,2,7,9,10,12,13},  '{1,3,6,8,11,12,13},
    '{0,1,4,7,10,13,15}, '{0,1,5,6,11,12,14}, '{2,3,5,6,8,13,15},   '{2,3,4,7,9,12,14},
    '{1,2,6,7,9,11,12},  '{0,3,6,7,8,10,13},  '{0,3,4,5,9,11,14},   '{1,2,4,5,8,10,15}
  };

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rotl(input logic [127:0] x, input int n);
    return (x << n) | (x >> (128 - n));
  endfunction

  function automatic logic [127:0] rotr(input logic [127:0] x, input int n);
    return (x >> n) | (x << (128 - n));
  endfunction

  function automatic logic [127:0] ek_m(input logic [127:0] a0, a1, a2, a3, input int j);
    logic [127:0] w [4];
    int g, k;
    w[0] = a0; w[1] = a1; w[2] = a2; w[3] = a3;
    if (j == 17) return a0 ^ rotl(a1, 19);
    g = (j - 1) / 4;
    k = (j - 1) % 4;
    case (g)
      0:       return w[k] ^ rotr(w[(k + 1) % 4], 19);
      1:       return w[k] ^ rotr(w[(k + 1) % 4], 31);
      2:       return w[k] ^ rotl(w[(k + 1) % 4], 61);
      default: return w[k] ^ rotl(w[(k + 1) % 4], 31);
    endcase
  endfunction

  function automatic logic [127:0] a_m(input logic [127:0] x);
    logic [127:0] y;
    logic [7:0]   b;
    y = '0;
    for (int o = 0; o < 16; o++) begin
      b = 8'h00;
      for (int t = 0; t < 7; t++) b ^= x[127 - 8 * atab[o][t] -: 8];
      y[127 - 8 * o -: 8] = b;
    end
    return y;
  endfunction

  function automatic int nk_of(input logic [1:0] ks);
    return (ks == 2'b10) ? 15 : (ks == 2'b11) ? 17 : 13;
  endfunction

  task automatic push_exp(input logic [127:0] a0, a1, a2, a3, input logic [1:0] ks, input logic dec);
    int nk;
    logic [127:0] k;
    nk = nk_of(ks);
    exp_data_q.delete();
    exp_idx_q.delete();
    for (int i = 1; i <= nk; i++) begin
      if (dec && DEC_BUILD) begin
        if (i == 1)       k = ek_m(a0, a1, a2, a3, nk);
        else if (i == nk) k = ek_m(a0, a1, a2, a3, 1);
        else              k = a_m(ek_m(a0, a1, a2, a3, nk + 1 - i));
      end else begin
        k = ek_m(a0, a1, a2, a3, i);
      end
      exp_data_q.push_back(k);
      exp_idx_q.push_back(5'(i));
    end
  endtask

  task automatic pulse_start(input logic [127:0] a0, a1, a2, a3, input logic [1:0] ks, input logic dec);
    @(negedge clk);
    w0 = a0; w1 = a1; w2 = a2; w3 = a3;
    st_ksize = ks; flg_dec = dec; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w0 = {4{$urandom()}}; w1 = {4{$urandom()}}; w2 = {4{$urandom()}}; w3 = {4{$urandom()}};
    st_ksize = 2'($urandom_range(0, 3)); flg_dec = ~dec;
  endtask

  // bp: ready pattern 1,0,0 repeating; inj: pulse start with new W mid-run
  task automatic run_keys(input logic [127:0] a0, a1, a2, a3, input logic [1:0] ks,
                          input logic dec, input bit bp, input bit inj, output int nx);
    int c, first_c, last_c, nk;
    bit stall, fin;
    logic [127:0] hd;
    logic [4:0] hi;
    logic [127:0] pd;
    logic [4:0] pi;
    nk = nk_of(ks);
    push_exp(a0, a1, a2, a3, ks, dec);
    rk_ready = 1'b1;
    pulse_start(a0, a1, a2, a3, ks, dec);
    chk("valid_after_start", 128'(rk_valid), 128'(1));
    chk("idx_after_start", 128'(rk_idx), 128'(1));
    chk("busy_after_start", 128'(busy), 128'(1));
    nx = 0; c = 0; first_c = -1; last_c = 0; stall = 0; fin = 0; hd = '0; hi = '0;
    while (!fin && c < 300) begin
      if (stall) begin
        chk("stall_data", rk_data, hd);
        chk("stall_idx", 128'(rk_idx), 128'(hi));
      end
      rk_ready = bp ? ((c % 3) == 0) : 1'b1;
      start = (inj && c == 3);
      if (inj && c == 3) w0 = ~a0;
      chk("no_early_done", 128'(done), 128'(0));
      stall = rk_valid && !rk_ready;
      hd = rk_data; hi = rk_idx;
      if (rk_valid && rk_ready) begin
        if (exp_data_q.size() == 0) begin
          chk("extra_xfer", 128'(1), 128'(0));
          fin = 1;
        end else begin
          pd = exp_data_q.pop_front();
          pi = exp_idx_q.pop_front();
          chk("xfer_idx", 128'(rk_idx), 128'(pi));
          chk("xfer_data", rk_data, pd);
          if (rk_idx >= 5'd1 && rk_idx <= 5'd17) cap[rk_idx] = rk_data;
          nx++;
          if (first_c < 0) first_c = c;
          last_c = c;
          if (exp_data_q.size() == 0) fin = 1;
        end
      end
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    if (!fin) chk("timeout", 128'(0), 128'(1));
    chk("done_pulse", 128'(done), 128'(1));
    chk("valid_low_after_last", 128'(rk_valid), 128'(0));
    @(negedge clk);
    chk("done_one_cycle", 128'(done), 128'(0));
    chk("busy_idle", 128'(busy), 128'(0));
    if (!bp) chk("burst_len", 128'(last_c - first_c), 128'(nk - 1));
    rk_ready = 1'b0;
  endtask

  int nx;
  logic [127:0] ra0, ra1, ra2, ra3;

  initial begin
    @(negedge clk);
    chk("rst_valid", 128'(rk_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_idx", 128'(rk_idx), 128'(0));
    chk("rst_data", rk_data, 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    run_keys(128'h1, '0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b0, nx);
    $display("run enc128 transfers %0d", nx);
    chk("enc128_count", 128'(nx), 128'(13));
    chk("enc128_key1", cap[1], 128'h1);
    chk("enc128_key4", cap[4], 128'h0000_2000_0000_0000_0000_0000_0000_0000);
    chk("enc128_key8", cap[8], 128'h0000_0002_0000_0000_0000_0000_0000_0000);

    run_keys(128'h1, '0, '0, '0, 2'b11, 1'b0, 1'b0, 1'b0, nx);
    $display("run enc256 transfers %0d", nx);
    chk("enc256_count", 128'(nx), 128'(17));
    chk("enc256_key17", cap[17], 128'h1);

    run_keys(128'h1, '0, '0, '0, 2'b10, 1'b0, 1'b0, 1'b0, nx);
    $display("run enc192 transfers %0d", nx);
    chk("enc192_count", 128'(nx), 128'(15));

    ra0 = {4{$urandom()}}; ra1 = {4{$urandom()}}; ra2 = {4{$urandom()}}; ra3 = {4{$urandom()}};
    run_keys(ra0, ra1, ra2, ra3, 2'b01, 1'b0, 1'b0, 1'b0, nx);
    $display("run enc128(01) random W transfers %0d", nx);
    chk("enc128b_count", 128'(nx), 128'(13));

    run_keys(ra3, ra0, ra2, ra1, 2'b00, 1'b0, 1'b1, 1'b0, nx);
    $display("run backpressure transfers %0d", nx);
    chk("bp_count", 128'(nx), 128'(13));

    run_keys(128'h1, '0, '0, '0, 2'b00, 1'b1, 1'b0, 1'b0, nx);
    $display("run dec-flag 128 transfers %0d", nx);
    chk("dec128_count", 128'(nx), 128'(13));
    chk("dec128_key1", cap[1], 128'h1);
    chk("dec128_key13", cap[13], 128'h1);

    run_keys(ra1, ra2, ra3, ra0, 2'b11, 1'b1, 1'b1, 1'b0, nx);
    $display("run dec-flag 256 backpressure transfers %0d", nx);
    chk("dec256_count", 128'(nx), 128'(17));

    run_keys(ra0, ra1, ra2, ra3, 2'b00, 1'b0, 1'b0, 1'b1, nx);
    $display("run start-injected transfers %0d", nx);
    chk("inj_count", 128'(nx), 128'(13));

    // clr when rk_idx reaches 5
    rk_ready = 1'b1;
    pulse_start(128'h1, '0, '0, '0, 2'b00, 1'b0);
    for (int c = 0; c < 40 && rk_idx != 5'd5; c++) @(negedge clk);
    chk("clr_reach_idx5", 128'(rk_idx), 128'(5));
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    rk_ready = 1'b0;
    $display("clr applied at idx 5");
    chk("clr_valid", 128'(rk_valid), 128'(0));
    chk("clr_busy", 128'(busy), 128'(0));
    chk("clr_idx", 128'(rk_idx), 128'(0));
    chk("clr_data", rk_data, 128'(0));
    chk("clr_done", 128'(done), 128'(0));
    @(negedge clk);
    chk("clr_no_done_later", 128'(done), 128'(0));

    // asynchronous reset mid-run
    rk_ready = 1'b1;
    pulse_start(ra2, ra3, ra0, ra1, 2'b00, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset mid-run");
    chk("arst_valid", 128'(rk_valid), 128'(0));
    chk("arst_busy", 128'(busy), 128'(0));
    chk("arst_idx", 128'(rk_idx), 128'(0));
    chk("arst_data", rk_data, 128'(0));
    chk("arst_done", 128'(done), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run_keys(ra2, ra3, ra0, ra1, 2'b00, 1'b0, 1'b0, 1'b0, nx);
    $display("run after reset transfers %0d", nx);
    chk("post_rst_count", 128'(nx), 128'(13));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
